// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock programmable FIFO.
package sync_fifo_pkg;

  // Output-mode selector values for the FWFT parameter.
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Pointer comparison result.
  typedef struct packed {
    logic full;
    logic empty;
  } ptr_status_t;

  // Number of words addressed by an asize-bit RAM address.
  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  // Full/empty from two (asize+1)-bit pointers, zero-extended to 32 bits.
  // Empty when the pointers match; full when only the wrap bit differs.
  function automatic ptr_status_t ptr_compare(input logic [31:0] wptr,
                                              input logic [31:0] rptr,
                                              input int unsigned asize);
    ptr_status_t s;
    logic [31:0] mask;
    logic [31:0] diff;
    mask    = (32'd1 << (asize + 32'd1)) - 32'd1;
    diff    = (wptr ^ rptr) & mask;
    s.empty = (diff == 32'd0);
    s.full  = (diff == (32'd1 << asize));
    return s;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DSIZE x 2^ASIZE storage: synchronous write, asynchronous read, no reset.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [DSIZE-1:0] wr_data,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [DSIZE-1:0] rd_data
);

  localparam int DEPTH = int'(fifo_depth(ASIZE));

  logic [DSIZE-1:0] mem [DEPTH];

  // Store the write word at the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a build-time choice of
// registered-read or first-word-fall-through output.
//
// Handshake: a write is taken at the rising edge iff wr_en && !o_fifo_full;
// a read is taken iff rd_en && !o_fifo_empty. A request that is not taken
// leaves the FIFO unchanged and raises the matching sticky error flag.
// Full blocks writes even when a read is taken in the same cycle.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int FWFT  = FWFT_OFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic [ASIZE:0]   aempty_thresh,
  input  logic             err_clr,
  output logic             o_fifo_full,
  output logic             o_fifo_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [ASIZE:0]   fill_level,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  ptr_status_t      status;
  logic             wr_accept;
  logic             rd_accept;
  logic [DSIZE-1:0] ram_q;

  assign status         = ptr_compare(32'(wptr), 32'(rptr), ASIZE);
  assign o_fifo_full    = status.full;
  assign o_fifo_empty   = status.empty;
  assign fill_level     = wptr - rptr;
  assign o_almost_full  = (fill_level >= afull_thresh);
  assign o_almost_empty = (fill_level <= aempty_thresh);

  assign wr_accept = wr_en && !status.full;
  assign rd_accept = rd_en && !status.empty;

  // Advance each pointer on an accepted transfer; both wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_accept) wptr <= wptr + 1'b1;
      if (rd_accept) rptr <= rptr + 1'b1;
    end
  end

  // Sticky error flags; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_en && status.full) o_overflow <= 1'b1;
      else if (err_clr)         o_overflow <= 1'b0;
      if (rd_en && status.empty) o_underflow <= 1'b1;
      else if (err_clr)          o_underflow <= 1'b0;
    end
  end

  fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wptr[ASIZE-1:0]),
    .wr_data(wr_data),
    .rd_addr(rptr[ASIZE-1:0]),
    .rd_data(ram_q)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head word is presented straight from the RAM whenever data is stored.
      assign rd_data  = ram_q;
      assign rd_valid = !status.empty;
    end else begin : g_regread
      logic [DSIZE-1:0] rd_data_q;
      logic             rd_valid_q;

      // Capture the head word on an accepted read; hold data otherwise.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept;
          if (rd_accept) rd_data_q <= ram_q;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO for same-domain buffering, complementing the dual-clock FIFO.
- Adds a fill-level output and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags.
- Adds a build-time mode switch between registered-read and first-word-fall-through (FWFT) output.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; depth DEPTH = 2^ASIZE words
FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_data  in  DSIZE  write data
rd_en  in  1  read request (FWFT: pop/acknowledge of the head word)
rd_data  out  DSIZE  read data
rd_valid  out  1  rd_data holds a valid word
afull_thresh  in  ASIZE+1  almost-full threshold
aempty_thresh  in  ASIZE+1  almost-empty threshold
err_clr  in  1  clears sticky error flags
o_fifo_full  out  1  DEPTH words stored
o_fifo_empty  out  1  no words stored
o_almost_full  out  1  fill_level >= afull_thresh
o_almost_empty  out  1  fill_level <= aempty_thresh
fill_level  out  ASIZE+1  stored word count, 0..DEPTH
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Pointers: wptr and rptr are ASIZE+1-bit binary counters; the low ASIZE bits address the RAM.
  - Both wrap modulo 2^(ASIZE+1).
  - fill_level = wptr - rptr, computed modulo 2^(ASIZE+1).
  - empty: wptr == rptr.
  - full: MSBs differ and low ASIZE bits are equal.
- Write acceptance: a write is accepted iff wr_en && !full. It stores wr_data at wptr and increments wptr at the clock edge.
- Read acceptance: a read is accepted iff rd_en && !empty, and increments rptr.
- Simultaneous read and write:
  - Both accepted: fill_level is unchanged.
  - When full: the read is accepted, the write is rejected and o_overflow is set. Full blocks writes regardless of a concurrent read.
  - When empty: the write is accepted, the read is rejected and o_underflow is set.
- Flags: all flags are combinational from the registered pointers. They reflect an accepted operation in the cycle after its clock edge.
- Sticky errors:
  - o_overflow sets on wr_en && full; o_underflow sets on rd_en && empty.
  - Both hold until err_clr or reset.
  - If err_clr and a set condition occur in the same cycle, the set wins.
- FWFT=0 (registered-read mode):
  - On an accepted read, rd_data <= mem[rptr] and rd_valid <= 1 at the same edge. Data is usable in the cycle after rd_en: latency 1.
  - rd_valid <= 0 on any cycle without an accepted read.
  - rd_data holds its last value when no read is accepted.
- FWFT=1 (first-word-fall-through mode):
  - rd_data = mem[rptr], combinational RAM read; rd_valid = !empty.
  - A word written into an empty FIFO is visible in the cycle after the write edge.
  - rd_en pops the head word.
  - rd_data is don't-care while rd_valid = 0.
- RAM: DEPTH x DSIZE, synchronous write, asynchronous read. It is not reset.
- Reset (rst = 0, immediate, no clock required):
  - wptr = rptr = 0, fill_level = 0, o_fifo_empty = 1, o_fifo_full = 0, o_almost_empty = 1.
  - o_almost_full = (afull_thresh == 0).
  - o_overflow = o_underflow = 0.
  - rd_valid = 0; rd_data = 0 in FWFT=0.
  - A reset mid-operation discards all contents.
- Thresholds: thresholds are sampled live and not registered. Values above DEPTH are legal; afull_thresh > DEPTH means o_almost_full never asserts.

Decomposition:
- Package sync_fifo_pkg holds:
  - Constants FWFT_OFF = 0 and FWFT_ON = 1.
  - A function computing DEPTH from ASIZE.
  - A function computing the full/empty comparison from two pointers.
- One natural sub-module: fifo_ram, a parametrised DSIZE x 2^ASIZE RAM with synchronous write and asynchronous read.
- Pointer, flag and output logic stay in the top level.

Test Plan:
All scenarios use DSIZE=8 and ASIZE=2 (DEPTH=4); FWFT=0 unless stated.
1. Fill and overflow: write 0xA1..0xA4 -> after the 4th write o_fifo_full=1 and fill_level=4. Write 0xA5 -> o_overflow=1 and 0xA5 is dropped. Read 4 times -> rd_data 0xA1, 0xA2, 0xA3, 0xA4, then o_fifo_empty=1.
2. Registered-read latency and underflow: write 0x55; next cycle assert rd_en -> the following cycle rd_valid=1 and rd_data=0x55. A further rd_en -> o_underflow=1. Pulse err_clr -> o_underflow=0.
3. FWFT=1: write 0x3C into an empty FIFO -> next cycle rd_valid=1 and rd_data=0x3C with no rd_en. Assert rd_en for one cycle -> rd_valid=0.
4. Simultaneous access, level 2: rd_en and wr_en together -> fill_level stays 2. At level 4, rd_en and wr_en together -> fill_level=3, o_overflow=1, and the read returns the oldest word.
5. Thresholds with afull_thresh=3 and aempty_thresh=1: step fill_level 0 through 4 -> o_almost_empty=1 at levels 0-1 only; o_almost_full=1 at levels 3-4 only.
6. Wrap and reset: 10 interleaved write/read pairs carrying 0x00..0x09 -> read order preserved across pointer wrap. Then fill to 3 and assert rst mid-cycle -> immediately o_fifo_empty=1, fill_level=0, all sticky flags 0.
